// File: rtl/uart_row_loader_pkg.sv
// ============================================================================
// Module   : uart_row_loader_pkg
// Brief    : Shared ASCII constants, error codes and parser states for the
//            UART row loader and its transmit-side counterpart.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_row_loader_pkg;

    localparam logic [7:0] c_CHAR_0  = 8'h30;
    localparam logic [7:0] c_CHAR_1  = 8'h31;
    localparam logic [7:0] c_CHAR_LF = 8'h0A;
    localparam logic [7:0] c_CHAR_CR = 8'h0D;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_SHORT   = 2'd2,
        ERR_LONG    = 2'd3
    } err_code_t;

    typedef enum logic [1:0] {
        ST_ROW     = 2'd0,
        ST_EOL     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    function automatic logic is_bit_char(input logic [7:0] b);
        return (b == c_CHAR_0) || (b == c_CHAR_1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_row_loader.sv
// ============================================================================
// Module   : uart_row_loader
// Brief    : Parses ASCII '0'/'1' rows from uartRx and writes each completed
//            row to the worker row-write port; sticky error reporting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_row_loader
    import uart_row_loader_pkg::*;
#(
    parameter int N = 14,
    parameter int M = 140
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     clear_err,
    output logic                     row_wr_en,
    output logic [$clog2(N+1)-1:0]   row_wr_addr,
    output logic [M:0]               row_wr_data,
    output logic                     load_done,
    output logic                     busy,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int ADDR_W = $clog2(N + 1);
    localparam int CNT_W  = $clog2(M + 2);

    localparam logic [ADDR_W-1:0] c_LAST_ROW  = ADDR_W'(N - 1);
    localparam logic [CNT_W-1:0]  c_LAST_CHAR = CNT_W'(M);

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_rowIdx;
    logic [M:0]          r_shift;
    logic                r_err;
    err_code_t           r_errCode;
    logic                r_wrEn;
    logic                r_loadDone;
    logic [ADDR_W-1:0]   r_wrAddr;
    logic [M:0]          r_wrData;

    logic                w_take;
    logic                w_isBit;
    logic                w_isLf;
    logic                w_errRaise;
    err_code_t           w_errCode;

    // Carriage returns are invisible to the parser so CRLF and LF text both load.
    always_comb begin
        w_take     = rx_valid && (rx_data != c_CHAR_CR);
        w_isBit    = is_bit_char(rx_data);
        w_isLf     = (rx_data == c_CHAR_LF);
        w_errRaise = 1'b0;
        w_errCode  = ERR_NONE;
        if (w_take) begin
            case (r_state)
                ST_ROW: begin
                    if (w_isLf && (r_count != '0)) begin
                        w_errRaise = 1'b1;
                        w_errCode  = ERR_SHORT;
                    end else if (!w_isBit && !w_isLf) begin
                        w_errRaise = 1'b1;
                        w_errCode  = ERR_ILLEGAL;
                    end
                end
                ST_EOL: begin
                    if (w_isBit) begin
                        w_errRaise = 1'b1;
                        w_errCode  = ERR_LONG;
                    end else if (!w_isLf) begin
                        w_errRaise = 1'b1;
                        w_errCode  = ERR_ILLEGAL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_ROW;
            r_count    <= '0;
            r_rowIdx   <= '0;
            r_shift    <= '0;
            r_err      <= 1'b0;
            r_errCode  <= ERR_NONE;
            r_wrEn     <= 1'b0;
            r_loadDone <= 1'b0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
        end else begin
            r_wrEn     <= 1'b0;
            r_loadDone <= 1'b0;

            // A fresh error in the same cycle as clear_err takes precedence.
            if (clear_err) begin
                r_err     <= 1'b0;
                r_errCode <= ERR_NONE;
            end
            if (w_errRaise) begin
                r_err <= 1'b1;
                if (!r_err || clear_err) begin
                    r_errCode <= w_errCode;
                end
            end

            if (w_take) begin
                case (r_state)
                    ST_ROW: begin
                        if (w_isBit) begin
                            r_shift <= {r_shift[M-1:0], rx_data[0]};
                            r_count <= r_count + 1'b1;
                            if (r_count == c_LAST_CHAR) begin
                                r_state <= ST_EOL;
                            end
                        end else if (w_isLf) begin
                            // Short row: the line already ended, so restart the frame here.
                            if (r_count != '0) begin
                                r_count  <= '0;
                                r_rowIdx <= '0;
                                r_shift  <= '0;
                            end
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end
                    ST_EOL: begin
                        if (w_isLf) begin
                            r_wrEn   <= 1'b1;
                            r_wrAddr <= r_rowIdx;
                            r_wrData <= r_shift;
                            r_count  <= '0;
                            r_state  <= ST_ROW;
                            if (r_rowIdx == c_LAST_ROW) begin
                                r_loadDone <= 1'b1;
                                r_rowIdx   <= '0;
                            end else begin
                                r_rowIdx <= r_rowIdx + 1'b1;
                            end
                        end else begin
                            r_state <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        if (w_isLf) begin
                            r_state  <= ST_ROW;
                            r_count  <= '0;
                            r_rowIdx <= '0;
                            r_shift  <= '0;
                        end
                    end
                    default: r_state <= ST_ROW;
                endcase
            end
        end
    end

    assign row_wr_en   = r_wrEn;
    assign row_wr_addr = r_wrAddr;
    assign row_wr_data = r_wrData;
    assign load_done   = r_loadDone;
    assign err         = r_err;
    assign err_code    = r_errCode;
    assign busy        = (r_rowIdx != '0) || (r_count != '0) || (r_state != ST_ROW);

endmodule

`default_nettype wire

// File: tb/tb_uart_row_loader.sv
// ============================================================================
// Module   : tb_uart_row_loader
// Brief    : Self-checking bench for uart_row_loader (N=2, M=7) with a
//            line-level reference model and randomized row traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_row_loader;

    localparam int N  = 2;
    localparam int M  = 7;
    localparam int AW = $clog2(N + 1);
    localparam int W  = M + 1;

    typedef logic [AW+W:0] wr_t;   // {load_done, addr, data}

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          clear_err;
    logic          row_wr_en;
    logic [AW-1:0] row_wr_addr;
    logic [W-1:0]  row_wr_data;
    logic          load_done;
    logic          busy;
    logic          err;
    logic [1:0]    err_code;

    int total = 0;
    int bad   = 0;

    wr_t obsQ[$];
    wr_t expQ[$];

    // Reference model state: the current line as a list of bits.
    bit  mLine[$];
    int  mRow;
    bit  mDisc;
    bit  mErr;
    int  mCode;

    always #5 clk = ~clk;

    uart_row_loader #(.N(N), .M(M)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .clear_err  (clear_err),
        .row_wr_en  (row_wr_en),
        .row_wr_addr(row_wr_addr),
        .row_wr_data(row_wr_data),
        .load_done  (load_done),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code)
    );

    function automatic void model_reset();
        mLine.delete();
        mRow  = 0;
        mDisc = 0;
        mErr  = 0;
        mCode = 0;
    endfunction

    function automatic void model_err(input int code);
        if (!mErr) mCode = code;
        mErr  = 1;
        mDisc = 1;
        mLine.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit clr);
        logic [W-1:0] d;
        if (clr) begin
            mErr  = 0;
            mCode = 0;
        end
        if (b == 8'h0D) return;
        if (mDisc) begin
            if (b == 8'h0A) begin
                mDisc = 0;
                mRow  = 0;
                mLine.delete();
            end
            return;
        end
        if (b == 8'h30 || b == 8'h31) begin
            if (mLine.size() == W) model_err(3);
            else mLine.push_back(b == 8'h31);
        end else if (b == 8'h0A) begin
            if (mLine.size() == 0) begin
                // blank line
            end else if (mLine.size() < W) begin
                model_err(2);
                mDisc = 0;
                mRow  = 0;
            end else begin
                d = '0;
                for (int i = 0; i < W; i++) d[W-1-i] = mLine[i];
                expQ.push_back({(mRow == N - 1), AW'(mRow), d});
                mRow = (mRow + 1) % N;
                mLine.delete();
            end
        end else begin
            model_err(1);
        end
    endfunction

    function automatic bit model_busy();
        return (mRow != 0) || (mLine.size() != 0) || mDisc;
    endfunction

    // All driving tasks start and end on a falling edge.
    task automatic drive(input logic [7:0] b, input bit clr);
        rx_data   = b;
        rx_valid  = 1'b1;
        clear_err = clr;
        @(negedge clk);
        model_byte(b, clr);
        if (row_wr_en) obsQ.push_back({load_done, row_wr_addr, row_wr_data});
    endtask

    task automatic idle();
        rx_valid  = 1'b0;
        clear_err = 1'b0;
        @(negedge clk);
        if (row_wr_en) obsQ.push_back({load_done, row_wr_addr, row_wr_data});
    endtask

    task automatic send_str(input string s, input bit b2b);
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], 1'b0);
            if (!b2b) idle();
        end
        idle();
    endtask

    task automatic pulse_clear();
        rx_valid  = 1'b0;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        mErr  = 0;
        mCode = 0;
    endtask

    task automatic test_reset();
        logic [AW+W+5:0] outs;
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0; clear_err = 1'b0;
        repeat (2) @(negedge clk);
        outs = {row_wr_en, row_wr_addr, row_wr_data, load_done, busy, err, err_code};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        outs = {row_wr_en, row_wr_addr, row_wr_data, load_done, busy, err, err_code};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL post_reset_outputs got=%h want=0", outs); end
    endtask

    task automatic test_frame();
        send_str("10000001\n01100000\n", 1'b0);
        total++;
        if (obsQ.size() != 2) begin
            bad++; $display("FAIL frame_writes got=%0d want=2", obsQ.size());
        end else begin
            total++;
            if (obsQ[0] !== {1'b0, 2'd0, 8'h81}) begin bad++; $display("FAIL frame_row0 got=%h want=%h", obsQ[0], {1'b0, 2'd0, 8'h81}); end
            total++;
            if (obsQ[1] !== {1'b1, 2'd1, 8'h60}) begin bad++; $display("FAIL frame_row1 got=%h want=%h", obsQ[1], {1'b1, 2'd1, 8'h60}); end
        end
        total++;
        if ({err, busy} !== 2'b00) begin bad++; $display("FAIL frame_err_busy got=%b want=00", {err, busy}); end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_crlf();
        send_str("10100101\015\n", 1'b0);
        total++;
        if (obsQ.size() != 1 || obsQ[0] !== {1'b0, 2'd0, 8'hA5}) begin
            bad++; $display("FAIL crlf_write count=%0d got=%h want=%h", obsQ.size(), (obsQ.size() > 0) ? obsQ[0] : wr_t'(0), {1'b0, 2'd0, 8'hA5});
        end
        total++;
        if ({busy, err} !== 2'b10) begin bad++; $display("FAIL crlf_busy_err got=%b want=10", {busy, err}); end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_short();
        send_str("1010\n", 1'b0);
        total++;
        if ({err, err_code, busy} !== 4'b1100 || obsQ.size() != 0) begin
            bad++; $display("FAIL short_row err=%b code=%0d busy=%b writes=%0d want err=1 code=2 busy=0 writes=0", err, err_code, busy, obsQ.size());
        end
        send_str("11111111\n", 1'b0);
        total++;
        if (obsQ.size() != 1 || obsQ[0] !== {1'b0, 2'd0, 8'hFF}) begin
            bad++; $display("FAIL short_recover count=%0d got=%h want=%h", obsQ.size(), (obsQ.size() > 0) ? obsQ[0] : wr_t'(0), {1'b0, 2'd0, 8'hFF});
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_illegal_clear();
        pulse_clear();
        total++;
        if ({err, err_code} !== 3'b000) begin bad++; $display("FAIL clear_pulse got=%b want=000", {err, err_code}); end
        send_str("101x", 1'b0);
        total++;
        if ({err, err_code, busy} !== 4'b1011) begin bad++; $display("FAIL illegal_char got err/code/busy=%b want=1011", {err, err_code, busy}); end
        send_str("0101\n", 1'b0);
        total++;
        if (obsQ.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL illegal_discard writes=%0d busy=%b want 0 0", obsQ.size(), busy); end
        pulse_clear();
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL illegal_clear err=%b want=0", err); end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_long();
        send_str("110011001", 1'b0);
        total++;
        if ({err, err_code} !== 3'b111) begin bad++; $display("FAIL long_row got=%b want=111", {err, err_code}); end
        send_str("\n", 1'b0);
        total++;
        if (obsQ.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL long_recover writes=%0d busy=%b want 0 0", obsQ.size(), busy); end
        pulse_clear();
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_clear_collision();
        send_str("1\n", 1'b0);
        drive("x", 1'b1);
        idle();
        total++;
        if ({err, err_code} !== 3'b101) begin bad++; $display("FAIL clear_collision got=%b want=101", {err, err_code}); end
        send_str("\n", 1'b0);
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_reset_midrow();
        logic [AW+W+5:0] outs;
        send_str("1011", 1'b0);
        #2 reset = 1'b1;
        #1 outs = {row_wr_en, row_wr_addr, row_wr_data, load_done, busy, err, err_code};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL midrow_reset_async got=%h want=0", outs); end
        @(negedge clk);
        @(negedge clk);
        outs = {row_wr_en, row_wr_addr, row_wr_data, load_done, busy, err, err_code};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL midrow_reset_hold got=%h want=0", outs); end
        reset = 1'b0;
        model_reset();
        obsQ.delete(); expQ.delete();
        send_str("00000001\n", 1'b0);
        total++;
        if (obsQ.size() != 1 || obsQ[0] !== {1'b0, 2'd0, 8'h01}) begin
            bad++; $display("FAIL midrow_after count=%0d got=%h want=%h", obsQ.size(), (obsQ.size() > 0) ? obsQ[0] : wr_t'(0), {1'b0, 2'd0, 8'h01});
        end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic test_back_to_back();
        // Row index is 1 here, so the first row closes the frame.
        send_str("11110000\n00001111\n", 1'b1);
        total++;
        if (obsQ.size() != 2) begin
            bad++; $display("FAIL b2b_writes got=%0d want=2", obsQ.size());
        end else begin
            total++;
            if (obsQ[0] !== {1'b1, 2'd1, 8'hF0}) begin bad++; $display("FAIL b2b_row0 got=%h want=%h", obsQ[0], {1'b1, 2'd1, 8'hF0}); end
            total++;
            if (obsQ[1] !== {1'b0, 2'd0, 8'h0F}) begin bad++; $display("FAIL b2b_row1 got=%h want=%h", obsQ[1], {1'b0, 2'd0, 8'h0F}); end
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
        obsQ.delete(); expQ.delete();
    endtask

    task automatic send_rand(input logic [7:0] b);
        drive(b, ($urandom_range(0, 11) == 0));
        if ($urandom_range(0, 2) != 0) idle();
    endtask

    task automatic test_random();
        int kind;
        int len;
        int pos;
        for (int r = 0; r < 60; r++) begin
            kind = $urandom_range(0, 9);
            len  = (kind == 7) ? $urandom_range(1, W - 1) :
                   (kind == 9) ? W + $urandom_range(1, 2) : W;
            pos  = $urandom_range(0, len - 1);
            for (int j = 0; j < len; j++) begin
                if (kind == 8 && j == pos) send_rand(8'h41 + 8'($urandom_range(0, 25)));
                else send_rand(8'h30 + 8'($urandom_range(0, 1)));
                if ($urandom_range(0, 15) == 0) send_rand(8'h0D);
            end
            if ($urandom_range(0, 1) == 0) send_rand(8'h0D);
            send_rand(8'h0A);
            if ($urandom_range(0, 7) == 0) send_rand(8'h0A);
        end
        idle();
        total++;
        if (obsQ.size() != expQ.size()) begin
            bad++; $display("FAIL rand_count got=%0d want=%0d", obsQ.size(), expQ.size());
        end else begin
            for (int i = 0; i < expQ.size(); i++) begin
                total++;
                if (obsQ[i] !== expQ[i]) begin bad++; $display("FAIL rand_write[%0d] got=%h want=%h", i, obsQ[i], expQ[i]); end
            end
        end
        total++;
        if ({err, err_code, busy} !== {mErr, 2'(mCode), model_busy()}) begin
            bad++; $display("FAIL rand_status got=%b want=%b", {err, err_code, busy}, {mErr, 2'(mCode), model_busy()});
        end
        obsQ.delete(); expQ.delete();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_crlf();
        test_short();
        test_illegal_clear();
        test_long();
        test_clear_collision();
        test_reset_midrow();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_row_loader.md
Name: uart_row_loader

Overview:
- Host-to-FPGA counterpart of the UART row reporter: parses ASCII rows of '0'/'1' characters arriving from uartRx and writes each completed row into a row memory or register file.
- A DTS, either a seed or a candidate to re-check, can be loaded using exactly the text format the board emits.
- Sits between uartRx (data/ready) and the worker row-write port; top-level command decoding stays outside this block.

Parameters:
n, 14, number of rows per frame (DTS blocks)
M, 140, highest mark index; each row is M+1 characters / M+1 bits

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_data  input  8  byte from uartRx
rx_valid  input  1  one-cycle strobe: rx_data valid (uartRx ready)
clear_err  input  1  one-cycle strobe: clears err and err_code
row_wr_en  output  1  one-cycle write strobe
row_wr_addr  output  $clog2(n+1)  row index being written, 0..n-1
row_wr_data  output  M+1  parsed row; bit M = first character received
load_done  output  1  one-cycle pulse after row n-1 is written
busy  output  1  high while a frame is partially received
err  output  1  sticky error flag
err_code  output  2  0 none, 1 illegal char, 2 short row, 3 long row

Behaviour:
- Reset (async, active-high): state=ROW, char count=0, row index=0, shift reg=0. All outputs are 0.
- Bytes are consumed only on cycles with rx_valid=1. '\r' (0x0D) is ignored in every state.
- ROW state:
  - '0'/'1' -> shift reg <= {shift[M-1:0], bit}; char count +1. When the count reaches M+1 -> EOL.
  - '\n' with count 0 -> ignored (blank line).
  - '\n' with 0 < count < M+1 -> error, code 2.
  - Any other byte -> error, code 1.
- EOL state:
  - '\n' -> next cycle: row_wr_en=1, row_wr_data=shift, row_wr_addr=row index. Row index +1, count=0, state=ROW.
  - '0'/'1' -> error, code 3.
  - Any other byte -> error, code 1.
- Write latency: row_wr_en is high exactly 1 cycle after the rx_valid cycle carrying the terminating '\n'. row_wr_data and row_wr_addr are registered and hold their values until the next write.
- Frame end: on the write of row n-1, load_done pulses in the same cycle as row_wr_en, and the row index wraps to 0. The next frame starts immediately, with no header or start character required.
- busy = (row index != 0) || (count != 0) || state != ROW.
- Error handling:
  - err <= 1 and err_code <= code; the first error code is kept until cleared.
  - Go to DISCARD: every byte is dropped until '\n', then state=ROW with count=0 and row index=0. The partial frame is abandoned and no write is issued for the bad row.
  - A row already written stays written.
  - An error on the '\n' itself (short row) goes straight to ROW, since the line has already ended.
- clear_err:
  - Clears err and err_code on the next cycle.
  - If a byte in the same cycle raises a new error, the new error wins and sets err and err_code.
  - clear_err does not affect the parse state.
- rx_valid is never asserted on consecutive cycles (UART rate). The block must still handle back-to-back strobes with no loss.
- Shift reg is M+1 bits; the char counter width is $clog2(M+2), so the counter never wraps.

Decomposition:
- Shared package holds the ASCII constants ('0', '1', '\n', '\r'), the err_code enumeration and the state encoding (ROW, EOL, DISCARD). The same character constants are reused by the transmit-side FSM.
- No sub-module is needed. The shift/count datapath and FSM fit in one module; uartRx is instantiated by the parent.

Test Plan:
- Bench uses n=2, M=7. Send "10000001\n01100000\n" -> writes (addr0, 0x81), then (addr1, 0x60) with load_done=1 on the second; err=0; busy=0 afterwards.
- "1010\r\n" in CRLF form with full length "10100101\r\n" -> single write 0xA5; '\r' ignored; busy=1 after the write (row 1 pending).
- "1010\n" -> err=1, err_code=2, no write, row index=0. A following "11111111\n" writes addr0=0xFF.
- "101x0101\n" -> err_code=1, bytes dropped until '\n', no write. clear_err then gives err=0.
- "110011001\n" (9 chars) -> err_code=3 on the 9th char, recovery at '\n', no write.
- Assert reset mid-row after 4 chars, then release and send "00000001\n" -> write addr0=0x01; outputs were 0 during reset.
